uart_rx_ovs: RTL and testbench
==============================

UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PARITY_EN, default 0, where 1 means a parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, where 1 selects odd parity and 0 selects even; ignored when PARITY_EN=0.
REQ-004 SHALL have parameter STOP_BITS, default 1, number of stop bits checked, legal values 1 or 2.
REQ-005 SHALL have parameter OVS, default 16, sample_tick pulses per bit period, even, legal range 8..32.
REQ-006 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port rx_line, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port sample_tick, input, 1 bit: one-clk pulse at OVS x baud rate.
REQ-010 SHALL have port rx_data, output, DATA_BITS bits: received word, LSB = first bit on the line.
REQ-011 SHALL have port rx_valid, output, 1 bit: rx_data and error flags are valid.
REQ-012 SHALL have port rx_ack, input, 1 bit: consumer accepts the word.
REQ-013 SHALL have port parity_err, output, 1 bit: parity mismatch for the held word.
REQ-014 SHALL have port frame_err, output, 1 bit: a stop bit was sampled low for the held word.
REQ-015 SHALL have port overrun, output, 1 bit: one-clk pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass rx_line through a 2-flop synchronizer that resets to 1; all decoding uses the synchronized value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; the counter and state advance only on clk edges where sample_tick=1.
REQ-018 In IDLE, a low synchronized line on a sample_tick SHALL enter START and clear the tick counter.
REQ-019 START SHALL resample the line after OVS/2 ticks (mid start bit); if it is high, the block SHALL return to IDLE with no output (false start); if it is low, the block SHALL enter DATA.
REQ-020 DATA SHALL sample one bit every OVS ticks, mid-bit, LSB first, then enter PARITY after DATA_BITS bits if PARITY_EN=1, otherwise STOP.
REQ-021 PARITY SHALL sample one bit after OVS ticks; error = (XOR of data bits XOR parity bit) != PARITY_ODD.
REQ-022 STOP SHALL sample STOP_BITS bits, OVS ticks apart; any stop bit sampled low sets the frame error.
REQ-023 On the final stop sample, the block SHALL return to IDLE on the same tick; the next start bit is detectable from the next sample_tick.
REQ-024 On frame completion with rx_valid=0, or rx_valid=1 and rx_ack=1 in the same cycle, the block SHALL load rx_data, parity_err and frame_err and set rx_valid=1 on the next clk.
REQ-025 On frame completion with rx_valid=1 and rx_ack=0, the block SHALL drop the new frame, leave held outputs unchanged, and pulse overrun for exactly one clk.
REQ-026 rx_ack with rx_valid=1 and no simultaneous completion SHALL clear rx_valid next clk; rx_data SHALL hold its value.
REQ-027 rx_ack with rx_valid=0 SHALL be ignored.
REQ-028 The block SHALL not stall: reception continues regardless of rx_valid.
REQ-029 Frames with frame_err still SHALL deliver data; a line held low (break) SHALL produce one frame_err word, then wait in IDLE until the line goes high before a new start is accepted.
REQ-030 Latency SHALL be rx_valid high exactly 1 clk after the sample_tick of the last stop sample.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force IDLE and set counters=0, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, and synchronizer=1.
REQ-032 Reset mid-frame SHALL discard the partial frame; after release, the block SHALL wait for a new falling edge.

Verification
REQ-033 8N1, OVS=16, send 0xA5 -> rx_valid=1 with rx_data=0xA5, parity_err=0, frame_err=0.
REQ-034 DATA_BITS=7, PARITY_EN=1, even parity, send 0x41 with parity bit 1 -> rx_data=0x41, parity_err=1.
REQ-035 Low glitch of 4 sample_ticks on an idle line -> returns to IDLE, rx_valid stays 0.
REQ-036 STOP_BITS=2, second stop bit driven low, data 0x3C -> rx_data=0x3C, frame_err=1.
REQ-037 Send 0x11 then 0x22 with rx_ack held 0 -> rx_data stays 0x11, one overrun pulse; rx_ack=1 -> rx_valid=0.
REQ-038 rst_n pulsed low after 3 data bits of 0xFF, then send 0x5A -> only 0x5A is delivered.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: mid-bit sampling on sample_tick, a one-word holding
// register with valid/ack handshake, parity and framing flags, and an overrun pulse.
module uart_rx_ovs #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVS        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_line,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [1:0]           sync;
  logic                 line;
  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 par_bit, par_bit_nx;
  logic                 stop_err, stop_err_nx;
  logic                 armed, armed_nx;
  logic                 frame_done, done_perr, done_ferr;

  assign line = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 2'b11;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      stop_err <= 1'b0;
      armed    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, independent of block order.
      sync     <= {sync[0], rx_line};
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      shift    <= shift_nx;
      par_bit  <= par_bit_nx;
      stop_err <= stop_err_nx;
      armed    <= armed_nx;
    end
  end

  // A start is only accepted once the line has been seen high (after reset or a break).
  always_comb begin
    // NOTE: every signal gets a default first; a path that skipped one would infer a latch.
    state_nx    = state;
    cnt_nx      = cnt;
    idx_nx      = idx;
    shift_nx    = shift;
    par_bit_nx  = par_bit;
    stop_err_nx = stop_err;
    armed_nx    = armed;
    frame_done  = 1'b0;
    if (sample_tick) begin
      case (state)
        IDLE: begin
          if (line) begin
            armed_nx = 1'b1;
          end else if (armed) begin
            state_nx = START;
            cnt_nx   = '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_nx      = '0;
            idx_nx      = '0;
            stop_err_nx = 1'b0;
            state_nx    = line ? IDLE : DATA;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt_nx   = '0;
            shift_nx = {line, shift[DATA_BITS-1:1]};
            if (idx == DATA_LAST) begin
              idx_nx   = '0;
              state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt_nx     = '0;
            par_bit_nx = line;
            state_nx   = STOP;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt_nx = '0;
            if (!line) stop_err_nx = 1'b1;
            if (idx == STOP_LAST) begin
              frame_done = 1'b1;
              idx_nx     = '0;
              armed_nx   = line;
              state_nx   = IDLE;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign done_ferr = stop_err | ~line;
  assign done_perr = (PARITY_EN != 0) && ((^shift ^ par_bit) != ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the holding register is reset as well, so rx_data reads 0 out of reset, not just rx_valid.
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ack) begin
          rx_data    <= shift;
          parity_err <= done_perr;
          frame_err  <= done_ferr;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed and randomized bench for uart_rx_ovs: three configurations (8N1, 7E1, 8N2)
// driven bit-by-bit against a frame-level reference model.
module tb_uart_rx_ovs;
  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] div = 2'd0;
  logic       sample_tick;
  logic [2:0] line = 3'b111;
  logic [2:0] ack = 3'b000;
  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic [2:0] valid, perr, ferr, ovr;

  int total = 0;
  int bad = 0;
  int tick_num = 0;
  bit tick_at_edge = 1'b0;
  int words[3] = '{0, 0, 0};
  int ovr_cycles[3] = '{0, 0, 0};
  logic [2:0] valid_d = 3'b000;
  int rise_tick_a = 0;
  bit rise_on_tick_a = 1'b0;
  int t_start = -1;

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign sample_tick = (div == 2'd3);

  uart_rx_ovs #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .OVS(OVS)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_line(line[0]), .sample_tick(sample_tick),
    .rx_data(data_a), .rx_valid(valid[0]), .rx_ack(ack[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));

  uart_rx_ovs #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .OVS(OVS)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_line(line[1]), .sample_tick(sample_tick),
    .rx_data(data_b), .rx_valid(valid[1]), .rx_ack(ack[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));

  uart_rx_ovs #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .OVS(OVS)) dut_c (
    .clk(clk), .rst_n(rst_n), .rx_line(line[2]), .sample_tick(sample_tick),
    .rx_data(data_c), .rx_valid(valid[2]), .rx_ack(ack[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));

  always @(posedge clk) begin
    tick_at_edge = sample_tick;
    if (sample_tick) tick_num = tick_num + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i] && !valid_d[i]) words[i] = words[i] + 1;
      if (ovr[i]) ovr_cycles[i] = ovr_cycles[i] + 1;
    end
    if (valid[0] && !valid_d[0]) begin
      rise_tick_a    = tick_num;
      rise_on_tick_a = tick_at_edge;
    end
    valid_d = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (sample_tick !== 1'b1);
    end
    #1;
  endtask

  function automatic int nbits(input int sel);
    return (sel == 1) ? 7 : 8;
  endfunction

  function automatic int nstop(input int sel);
    return (sel == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] get_data(input int sel);
    case (sel)
      0:       return {1'b0, data_a};
      1:       return {2'b00, data_b};
      default: return {1'b0, data_c};
    endcase
  endfunction

  // Reference model: expected word and flags computed from the frame fields.
  function automatic logic [8:0] exp_data(input int sel, input logic [8:0] d);
    return (sel == 1) ? (d & 9'h07f) : (d & 9'h0ff);
  endfunction

  function automatic logic exp_perr(input int sel, input logic [8:0] d, input logic p);
    if (sel != 1) return 1'b0;
    return (($countones(d[6:0]) + int'(p)) % 2) != 0;
  endfunction

  function automatic logic exp_ferr(input int sel, input logic [1:0] s);
    return (sel == 2) ? !(s[0] && s[1]) : !s[0];
  endfunction

  function automatic int done_tick(input int sel, input int t0);
    return t0 + 1 + OVS / 2 + OVS * (nbits(sel) + ((sel == 1) ? 1 : 0) + nstop(sel));
  endfunction

  task automatic send(input int sel, input logic [8:0] d, input logic p, input logic [1:0] s,
                      output int t0);
    wait_ticks(2);
    t0 = tick_num;
    t_start = t0;
    line[sel] = 1'b0;
    wait_ticks(OVS);
    for (int i = 0; i < nbits(sel); i++) begin
      line[sel] = d[i];
      wait_ticks(OVS);
    end
    if (sel == 1) begin
      line[sel] = p;
      wait_ticks(OVS);
    end
    for (int i = 0; i < nstop(sel); i++) begin
      line[sel] = s[i];
      wait_ticks(OVS);
    end
    line[sel] = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_word(input string tag, input int sel, input logic [8:0] d,
                            input logic pe, input logic fe);
    check({tag, "_valid"}, valid[sel], 1'b1);
    check({tag, "_data"}, get_data(sel), d);
    check({tag, "_perr"}, perr[sel], pe);
    check({tag, "_ferr"}, ferr[sel], fe);
  endtask

  task automatic ack_word(input int sel);
    @(posedge clk);
    #1 ack[sel] = 1'b1;
    @(posedge clk);
    #1 ack[sel] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t0, w, o, comp, guard;
    logic [8:0] d;
    logic p;
    logic [1:0] s;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 3'b000);
    check("rst_data_a", data_a, 8'h00);
    check("rst_data_b", data_b, 7'h00);
    check("rst_data_c", data_c, 8'h00);
    check("rst_flags", {perr, ferr, ovr}, 9'h000);
    rst_n = 1'b1;
    wait_ticks(2);

    // 8N1 0xA5, exact latency, ack clears valid but holds data
    send(0, 9'h0a5, 1'b0, 2'b11, t0);
    check_word("a5", 0, 9'h0a5, 1'b0, 1'b0);
    check("a5_lat_tick", rise_tick_a, done_tick(0, t0));
    check("a5_lat_edge", rise_on_tick_a, 1'b1);
    ack_word(0);
    check("a5_ack_valid", valid[0], 1'b0);
    check("a5_ack_hold", data_a, 8'ha5);
    w = words[0];
    ack_word(0);
    check("ack_idle_ignored", valid[0], 1'b0);
    check("ack_idle_words", words[0], w);

    // 7E1: 0x41 with parity bit 1 is an error, with 0 it is not
    send(1, 9'h041, 1'b1, 2'b11, t0);
    check_word("p41_bad", 1, 9'h041, 1'b1, 1'b0);
    ack_word(1);
    send(1, 9'h041, 1'b0, 2'b11, t0);
    check_word("p41_good", 1, 9'h041, 1'b0, 1'b0);
    ack_word(1);

    // Four-tick low glitch is a false start
    w = words[0];
    wait_ticks(1);
    line[0] = 1'b0;
    wait_ticks(4);
    line[0] = 1'b1;
    wait_ticks(3 * OVS);
    check("glitch_valid", valid[0], 1'b0);
    check("glitch_words", words[0], w);

    // 8N2: second stop bit low
    send(2, 9'h03c, 1'b0, 2'b01, t0);
    check_word("stop2_low", 2, 9'h03c, 1'b0, 1'b1);
    ack_word(2);

    // Overrun: second frame dropped while first is held
    w = words[0];
    o = ovr_cycles[0];
    send(0, 9'h011, 1'b0, 2'b11, t0);
    check_word("ovr_first", 0, 9'h011, 1'b0, 1'b0);
    send(0, 9'h022, 1'b0, 2'b11, t0);
    check_word("ovr_hold", 0, 9'h011, 1'b0, 1'b0);
    check("ovr_pulse_clks", ovr_cycles[0] - o, 1);
    check("ovr_words", words[0] - w, 1);
    ack_word(0);
    check("ovr_ack_valid", valid[0], 1'b0);

    // Ack landing on the completion clock: new word replaces old, no overrun
    send(0, 9'h033, 1'b0, 2'b11, t0);
    w = words[0];
    o = ovr_cycles[0];
    t_start = -1;
    fork
      send(0, 9'h044, 1'b0, 2'b11, t0);
      begin
        guard = 0;
        while (t_start < 0) @(negedge clk);
        comp = done_tick(0, t_start);
        while (tick_num < comp - 1 && guard < 5000) begin
          @(negedge clk);
          guard++;
        end
        check("sim_ack_bound", guard < 5000, 1'b1);
        repeat (3) @(posedge clk);
        #1 ack[0] = 1'b1;
        @(posedge clk);
        #1 ack[0] = 1'b0;
      end
    join
    check_word("sim_ack", 0, 9'h044, 1'b0, 1'b0);
    check("sim_ack_ovr", ovr_cycles[0] - o, 0);
    check("sim_ack_words", words[0] - w, 0);
    ack_word(0);

    // Break: one framing-error word, then no restart until the line rises
    w = words[0];
    o = ovr_cycles[0];
    wait_ticks(2);
    line[0] = 1'b0;
    wait_ticks(11 * OVS);
    @(negedge clk);
    check_word("break", 0, 9'h000, 1'b0, 1'b1);
    check("break_words", words[0] - w, 1);
    ack_word(0);
    wait_ticks(25 * OVS);
    @(negedge clk);
    check("break_hold_valid", valid[0], 1'b0);
    check("break_hold_words", words[0] - w, 1);
    check("break_hold_ovr", ovr_cycles[0] - o, 0);
    line[0] = 1'b1;
    wait_ticks(OVS);
    send(0, 9'h096, 1'b0, 2'b11, t0);
    check_word("after_break", 0, 9'h096, 1'b0, 1'b0);

    // Asynchronous reset mid-frame with a word held, then a clean frame
    wait_ticks(2);
    line[0] = 1'b0;
    wait_ticks(OVS);
    line[0] = 1'b1;
    wait_ticks(2 * OVS + OVS / 2);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", valid[0], 1'b0);
    check("async_rst_data", data_a, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(8 * OVS);
    @(negedge clk);
    check("rst_partial_valid", valid[0], 1'b0);
    w = words[0];
    send(0, 9'h05a, 1'b0, 2'b11, t0);
    check_word("rst_5a", 0, 9'h05a, 1'b0, 1'b0);
    check("rst_5a_words", words[0] - w, 1);
    ack_word(0);

    // Randomized frames on all three configurations
    for (int n = 0; n < 8; n++) begin
      for (int sel = 0; sel < 3; sel++) begin
        d = 9'($urandom_range(0, 511));
        p = 1'($urandom_range(0, 1));
        s = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        send(sel, d, p, s, t0);
        check_word($sformatf("rnd%0d_%0d", n, sel), sel, exp_data(sel, d),
                   exp_perr(sel, d, p), exp_ferr(sel, s));
        ack_word(sel);
        check($sformatf("rnd%0d_%0d_ack", n, sel), valid[sel], 1'b0);
      end
    end
    check("rnd_no_overrun", ovr_cycles[1] + ovr_cycles[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
